// File: rtl/sim_monitor_pkg.sv
// Shared types and helpers for the simulation-control / performance monitor.
package sim_monitor_pkg;

    localparam int RD_W  = 5;
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_MAX_CYCLES = 2'd1,
        CAUSE_END_PC     = 2'd2,
        CAUSE_WATCHDOG   = 2'd3
    } cause_t;

    // Unsigned add clamped to the all-ones value of a w-bit counter (1 <= w <= SAT_W).
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int               w);
        logic [SAT_W:0]   sum;
        logic [SAT_W-1:0] lim;
        lim = {SAT_W{1'b1}} >> (SAT_W - w);
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim})
            return lim;
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/retire_popcount.sv
// Combinational population count of the per-lane counted-retire vector.
module retire_popcount #(
    parameter int NUM_RET = 1,
    parameter int POP_W   = $clog2(NUM_RET + 1)
) (
    input  logic [NUM_RET-1:0] vec,
    output logic [POP_W-1:0]   count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_RET; i++)
            count = count + POP_W'(vec[i]);
    end

endmodule

// File: rtl/sim_monitor.sv
// Bench-side run controller: counts RUN cycles and retires, stops on end PC,
// no-retire watchdog or cycle limit, and latches why it stopped.
module sim_monitor
    import sim_monitor_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_RET     = 1,
    parameter int CNT_W       = 32,
    parameter int COUNT_MODE  = 1,
    parameter int WDOG_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        max_cycles,
    input  logic [XLEN-1:0]         end_pc,
    input  logic                    end_pc_en,
    input  logic [NUM_RET-1:0]      retire_valid,
    input  logic [NUM_RET*XLEN-1:0] retire_pc,
    input  logic [NUM_RET-1:0]      retire_rd_we,
    input  logic [NUM_RET*RD_W-1:0] retire_rd,
    output logic                    running,
    output logic                    done,
    output logic                    done_pulse,
    output logic [1:0]              done_cause,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [CNT_W-1:0]        instr_cnt
);

    localparam int POP_W  = $clog2(NUM_RET + 1);
    localparam int IDLE_W = 32;

    state_t             state_q, state_d;
    cause_t             cause_q, cause_d;
    logic [CNT_W-1:0]   cycle_q, instr_q, max_cycles_q;
    logic [CNT_W-1:0]   cycle_nxt, instr_nxt;
    logic [XLEN-1:0]    end_pc_q;
    logic               end_pc_en_q;
    logic [IDLE_W-1:0]  idle_q, idle_nxt;
    logic               done_pulse_q;
    logic [NUM_RET-1:0] counted;
    logic [POP_W-1:0]   pop;
    logic               end_hit, wdog_hit, max_hit, start_ok;

    always_comb begin
        counted = '0;
        end_hit = 1'b0;
        for (int i = 0; i < NUM_RET; i++) begin
            if (COUNT_MODE == 1)
                counted[i] = retire_valid[i] && retire_rd_we[i] &&
                             (retire_rd[i*RD_W +: RD_W] != '0);
            else
                counted[i] = retire_valid[i];
            if (end_pc_en_q && retire_valid[i] && (retire_pc[i*XLEN +: XLEN] == end_pc_q))
                end_hit = 1'b1;
        end
    end

    retire_popcount #(.NUM_RET(NUM_RET), .POP_W(POP_W)) u_popcount (
        .vec   (counted),
        .count (pop)
    );

    // Candidate next counter values; termination tests look at these so the
    // stopping cycle's own retires are already included.
    always_comb begin
        cycle_nxt = CNT_W'(sat_add(SAT_W'(cycle_q), SAT_W'(1), CNT_W));
        instr_nxt = CNT_W'(sat_add(SAT_W'(instr_q), SAT_W'(pop), CNT_W));
        idle_nxt  = (|retire_valid) ? '0
                                    : IDLE_W'(sat_add(SAT_W'(idle_q), SAT_W'(1), IDLE_W));
        wdog_hit  = (WDOG_CYCLES != 0) && (idle_nxt == IDLE_W'(WDOG_CYCLES));
        max_hit   = (max_cycles_q != '0) && (cycle_nxt == max_cycles_q);
        start_ok  = start && (state_q != RUN);
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cause_d = CAUSE_NONE;
                end
            end
            RUN: begin
                if (end_hit) begin
                    state_d = DONE;
                    cause_d = CAUSE_END_PC;
                end else if (wdog_hit) begin
                    state_d = DONE;
                    cause_d = CAUSE_WATCHDOG;
                end else if (max_hit) begin
                    state_d = DONE;
                    cause_d = CAUSE_MAX_CYCLES;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cause_q      <= CAUSE_NONE;
            done_pulse_q <= 1'b0;
            cycle_q      <= '0;
            instr_q      <= '0;
            idle_q       <= '0;
            max_cycles_q <= '0;
            end_pc_q     <= '0;
            end_pc_en_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            done_pulse_q <= (state_q == RUN) && (state_d == DONE);
            if (start_ok) begin
                cycle_q      <= '0;
                instr_q      <= '0;
                idle_q       <= '0;
                max_cycles_q <= max_cycles;
                end_pc_q     <= end_pc;
                end_pc_en_q  <= end_pc_en;
            end else if (state_q == RUN) begin
                cycle_q <= cycle_nxt;
                instr_q <= instr_nxt;
                idle_q  <= idle_nxt;
            end
        end
    end

    assign running    = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign done_pulse = done_pulse_q;
    assign done_cause = cause_q;
    assign cycle_cnt  = cycle_q;
    assign instr_cnt  = instr_q;

endmodule

// File: tb/tb_sim_monitor.sv
// Scoreboard bench for sim_monitor: scripted and random runs checked against a per-run reference model.
module tb_sim_monitor;

    localparam int XLEN   = 16;
    localparam int NR     = 2;
    localparam int CNT_W  = 6;
    localparam int WDOG   = 5;
    localparam int MAXLEN = 80;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n, start, end_pc_en;
    logic [CNT_W-1:0]  max_cycles;
    logic [XLEN-1:0]   end_pc;
    logic [NR-1:0]     retire_valid, retire_rd_we;
    logic [NR*XLEN-1:0] retire_pc;
    logic [NR*5-1:0]   retire_rd;
    logic              running, done, done_pulse;
    logic [1:0]        done_cause;
    logic [CNT_W-1:0]  cycle_cnt, instr_cnt;

    always #5 clk = ~clk;

    sim_monitor #(
        .XLEN(XLEN), .NUM_RET(NR), .CNT_W(CNT_W), .COUNT_MODE(1), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .max_cycles(max_cycles),
        .end_pc(end_pc), .end_pc_en(end_pc_en), .retire_valid(retire_valid),
        .retire_pc(retire_pc), .retire_rd_we(retire_rd_we), .retire_rd(retire_rd),
        .running(running), .done(done), .done_pulse(done_pulse),
        .done_cause(done_cause), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    typedef struct {
        int evt; int run; int dn; int pulse; int cause; int cyc; int ins;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic snap_req = 1'b0;

    // Run script: one entry per RUN cycle.
    logic [NR-1:0]   s_rv [MAXLEN];
    logic [NR-1:0]   s_we [MAXLEN];
    logic [XLEN-1:0] s_pc [MAXLEN][NR];
    logic [4:0]      s_rd [MAXLEN][NR];
    bit              s_start [MAXLEN];
    int              s_len, s_max;
    logic [XLEN-1:0] s_epc;
    bit              s_epc_en;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (snap_req || done_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: got snap=%0d pulse=%0d expected no event (t=%0t)",
                         snap_req, done_pulse, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("event_kind", snap_req ? 0 : 1, e.evt);
                check("running", int'(running), e.run);
                check("done", int'(done), e.dn);
                check("done_pulse", int'(done_pulse), e.pulse);
                check("done_cause", int'(done_cause), e.cause);
                check("cycle_cnt", int'(cycle_cnt), e.cyc);
                check("instr_cnt", int'(instr_cnt), e.ins);
            end
        end
    end

    task automatic push(input int evt, run, dn, pulse, cause, cyc, ins);
        exp_t e;
        e.evt = evt; e.run = run; e.dn = dn; e.pulse = pulse;
        e.cause = cause; e.cyc = cyc; e.ins = ins;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_script();
        for (int k = 0; k < MAXLEN; k++) begin
            s_rv[k] = '0; s_we[k] = '0; s_start[k] = 1'b0;
            for (int l = 0; l < NR; l++) begin
                s_pc[k][l] = '0;
                s_rd[k][l] = '0;
            end
        end
        s_max = 0; s_epc = '0; s_epc_en = 1'b0; s_len = 1;
    endtask

    // Reference model: walks the script cycle by cycle using plain integers.
    task automatic model(output int cause, output int cyc, output int ins, output int term);
        int idle, n;
        bit any, hit;
        cause = 0; cyc = 0; ins = 0; term = 0; idle = 0;
        for (int k = 0; k < s_len; k++) begin
            n = 0; any = 1'b0; hit = 1'b0;
            for (int l = 0; l < NR; l++) begin
                if (s_rv[k][l]) begin
                    any = 1'b1;
                    if (s_we[k][l] && s_rd[k][l] != 0) n++;
                    if (s_epc_en && s_pc[k][l] == s_epc) hit = 1'b1;
                end
            end
            cyc  = (cyc < CMAX) ? cyc + 1 : CMAX;
            ins  = (ins + n > CMAX) ? CMAX : ins + n;
            idle = any ? 0 : idle + 1;
            if (hit) cause = 2;
            else if (idle == WDOG) cause = 3;
            else if (s_max != 0 && cyc == s_max) cause = 1;
            if (cause != 0) begin
                term = k + 1;
                return;
            end
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; retire_valid = '0; retire_rd_we = '0;
        retire_pc = '0; retire_rd = '0;
    endtask

    task automatic run_script();
        int cause, cyc, ins, term;
        model(cause, cyc, ins, term);
        if (term > 0)
            for (int k = term; k < MAXLEN; k++) s_start[k] = 1'b0;
        if (cause != 0) push(1, 0, 1, 1, cause, cyc, ins);

        idle_inputs();
        start      = 1'b1;
        max_cycles = CNT_W'(s_max);
        end_pc     = s_epc;
        end_pc_en  = s_epc_en;
        tick();
        for (int k = 0; k < s_len; k++) begin
            start        = s_start[k];
            max_cycles   = CNT_W'($urandom);
            end_pc       = XLEN'($urandom);
            end_pc_en    = 1'($urandom);
            retire_valid = s_rv[k];
            retire_rd_we = s_we[k];
            for (int l = 0; l < NR; l++) begin
                retire_pc[l*XLEN +: XLEN] = s_pc[k][l];
                retire_rd[l*5 +: 5]       = s_rd[k][l];
            end
            tick();
        end
        idle_inputs();

        if (cause != 0) begin
            tick();
            tick();
            push(0, 0, 1, 0, cause, cyc, ins);
            snap_req = 1'b1;
            tick();
            snap_req = 1'b0;
        end else begin
            push(0, 1, 0, 0, 0, cyc, ins);
            snap_req = 1'b1;
            rst_n    = 1'b0;
            tick();
            push(0, 0, 0, 0, 0, 0, 0);
            tick();
            snap_req = 1'b0;
            rst_n    = 1'b1;
        end
    endtask

    task automatic random_script();
        int gap;
        clear_script();
        gap      = 0;
        s_len    = $urandom_range(4, 60);
        s_max    = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63);
        s_epc_en = 1'($urandom_range(0, 1));
        s_epc    = XLEN'(16'h0100 + 4 * $urandom_range(0, 3));
        for (int k = 0; k < s_len; k++) begin
            if (gap > 0) begin
                gap--;
                s_rv[k] = '0;
            end else if ($urandom_range(0, 11) == 0) begin
                gap     = $urandom_range(1, 6);
                s_rv[k] = '0;
            end else begin
                s_rv[k] = NR'($urandom_range(0, 3));
            end
            s_we[k]    = NR'($urandom_range(0, 3));
            s_start[k] = ($urandom_range(0, 15) == 0);
            for (int l = 0; l < NR; l++) begin
                s_rd[k][l] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                s_pc[k][l] = ($urandom_range(0, 7) == 0) ? XLEN'(16'h0100 + 4 * $urandom_range(0, 3))
                                                         : XLEN'(4 * $urandom_range(0, 60));
            end
        end
    endtask

    task automatic set_lane(input int k, input int l, input int pc, input int rd);
        s_rv[k][l] = 1'b1;
        s_we[k][l] = 1'b1;
        s_pc[k][l] = XLEN'(pc);
        s_rd[k][l] = 5'(rd);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        max_cycles = '0; end_pc = '0; end_pc_en = 1'b0;
        tick();
        tick();
        push(0, 0, 0, 0, 0, 0, 0);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Cycle limit with one retire per cycle.
        clear_script();
        s_len = 25; s_max = 20;
        for (int k = 0; k < s_len; k++) set_lane(k, 0, 4 * k, 1);
        run_script();

        // Alternating rd=0/rd=5, stopped at the tenth retire's PC.
        clear_script();
        s_len = 12; s_epc_en = 1'b1; s_epc = XLEN'(16'h0064);
        for (int k = 0; k < 10; k++) set_lane(k, 0, 16'h0040 + 4 * k, (k % 2 == 0) ? 0 : 5);
        run_script();

        // End PC on lane 1 in the same cycle as the cycle limit.
        clear_script();
        s_len = 10; s_max = 7; s_epc_en = 1'b1; s_epc = XLEN'(16'h0100);
        for (int k = 0; k < s_len; k++) begin
            set_lane(k, 0, 16'h0010 + 8 * k, 3);
            set_lane(k, 1, (k == 6) ? 16'h0100 : 16'h0014 + 8 * k, 3);
        end
        run_script();

        // Watchdog after three retires.
        clear_script();
        s_len = 12;
        for (int k = 0; k < 3; k++) set_lane(k, 0, 4 * k, 2);
        run_script();

        // Instruction counter saturation, stays running.
        clear_script();
        s_len = 40;
        for (int k = 0; k < s_len; k++) begin
            set_lane(k, 0, 8 * k, 1);
            set_lane(k, 1, 8 * k + 4, 1);
        end
        run_script();

        // Cycle counter saturation with no limit, sparse retires.
        clear_script();
        s_len = 70;
        for (int k = 0; k < s_len; k += 3) set_lane(k, 0, 4 * k, 2);
        run_script();

        // Reset during RUN cycle 5, then a fresh run.
        clear_script();
        s_len = 5;
        for (int k = 0; k < s_len; k++) set_lane(k, 0, 4 * k, 7);
        run_script();
        clear_script();
        s_len = 9; s_max = 6;
        for (int k = 0; k < s_len; k++) set_lane(k, 1, 4 * k, 9);
        run_script();

        for (int r = 0; r < 30; r++) begin
            random_script();
            run_script();
        end

        tick();
        tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
